// File: rtl/dbus_req_arbiter.sv
// dbus_req_arbiter
//   Shares the single data-bus port between two masters. M0 is the commit-stage
//   load/store/cache-op port and normally has priority. M1 is the secondary master
//   (store drain / cache-op walker) and is guaranteed a grant after waiting
//   STARVE_LIMIT cycles. Accepted requests are tracked in issue order, so each bus
//   response is routed back to the master that issued it.
//
// Ports
//   clk, reset            clock; synchronous active-low reset
//   m0_* / m1_*           master request channels: req, wr, addr, size, wstrb, wdata in;
//                         addr_ok (request accepted) and data_ok (response) out
//   rdata                 bus read data, shared by both masters, valid with mX_data_ok
//   bus_req, bus_wr, bus_addr, bus_size, bus_wstrb, bus_wdata
//                         request and payload of the granted master
//   bus_addr_ok           bus accepted bus_req this cycle
//   bus_data_ok           bus returns the oldest outstanding response this cycle
//   bus_rdata             bus read data
//   busy                  at least one accepted request still waits for its response
//   err_spurious          sticky: a response arrived while nothing was outstanding
module dbus_req_arbiter #(
    parameter int MAX_OUT      = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [31:0] m0_addr,
    input  logic [1:0]  m0_size,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_wdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [31:0] m1_addr,
    input  logic [1:0]  m1_size,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_wdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        busy,
    output logic        err_spurious
);

    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic               grant_lock;
    logic               lock_id;
    logic [MAX_OUT-1:0] id_q;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      count;
    logic [SW-1:0]      starve_cnt;

    logic grant;        // 0 = M0, 1 = M1
    logic lock_live;
    logic starved;
    logic push;
    logic pop;

    // A lock whose master withdrew its request is stale: arbitrate normally so
    // nothing is pushed on its behalf, and the lock is rewritten this cycle.
    assign lock_live = grant_lock & (lock_id ? m1_req : m0_req);
    assign starved   = (starve_cnt >= SW'(STARVE_LIMIT)) & m1_req;

    always_comb begin
        grant = 1'b0;
        if (lock_live)
            grant = lock_id;
        else if (m0_req & ~starved)
            grant = 1'b0;
        else if (m1_req)
            grant = 1'b1;
    end

    // Depends only on registered count, never on bus_data_ok.
    assign bus_req   = (m0_req | m1_req) & (count < CW'(MAX_OUT));
    assign bus_wr    = grant ? m1_wr    : m0_wr;
    assign bus_addr  = grant ? m1_addr  : m0_addr;
    assign bus_size  = grant ? m1_size  : m0_size;
    assign bus_wstrb = grant ? m1_wstrb : m0_wstrb;
    assign bus_wdata = grant ? m1_wdata : m0_wdata;

    assign push       = bus_req & bus_addr_ok;
    assign pop        = bus_data_ok & (count != '0);
    assign m0_addr_ok = push & ~grant;
    assign m1_addr_ok = push & grant;
    assign m0_data_ok = pop & ~id_q[rd_ptr];
    assign m1_data_ok = pop & id_q[rd_ptr];
    assign rdata      = bus_rdata;
    assign busy       = (count != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            grant_lock   <= 1'b0;
            lock_id      <= 1'b0;
            id_q         <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            starve_cnt   <= '0;
            err_spurious <= 1'b0;
        end else begin
            // Hold the shown grant until the bus takes it so the payload stays stable.
            grant_lock <= bus_req & ~bus_addr_ok;
            lock_id    <= grant;

            if (push) begin
                id_q[wr_ptr] <= grant;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (m1_req & ~m1_addr_ok) begin
                if (starve_cnt < SW'(STARVE_LIMIT))
                    starve_cnt <= starve_cnt + SW'(1);
            end else begin
                starve_cnt <= '0;
            end

            if (bus_data_ok & (count == '0))
                err_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dbus_req_arbiter.sv
module tb_dbus_req_arbiter;

    localparam int MAX_OUT      = 4;
    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [1:0]  m0_size, m1_size;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0] rdata;
    logic        bus_req, bus_wr;
    logic [31:0] bus_addr, bus_wdata;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        busy, err_spurious;

    always #5 clk = ~clk;

    dbus_req_arbiter #(.MAX_OUT(MAX_OUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_size(m0_size),
        .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_size(m1_size),
        .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok),
        .rdata(rdata), .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
        .bus_size(bus_size), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .busy(busy), .err_spurious(err_spurious)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: ordered list of issuing masters, who holds the bus,
    // how long M1 has been waiting, sticky error.
    int q_ids[$];
    bit lk;
    int lk_m;
    int starve;
    bit err_m;
    bit mvalid = 1'b0;

    bit e_req, e_aok0, e_aok1, e_dok0, e_dok1;
    int e_gnt;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        bit lock_act, starved;
        #3;
        lock_act = lk && ((lk_m == 0) ? m0_req : m1_req);
        starved  = (starve >= STARVE_LIMIT) && m1_req;
        if (lock_act)               e_gnt = lk_m;
        else if (m0_req && !starved) e_gnt = 0;
        else if (m1_req)            e_gnt = 1;
        else                        e_gnt = 0;
        e_req  = (m0_req || m1_req) && (q_ids.size() < MAX_OUT);
        e_aok0 = bus_addr_ok && e_req && (e_gnt == 0);
        e_aok1 = bus_addr_ok && e_req && (e_gnt == 1);
        e_dok0 = bus_data_ok && (q_ids.size() != 0) && (q_ids[0] == 0);
        e_dok1 = bus_data_ok && (q_ids.size() != 0) && (q_ids[0] == 1);
        if (mvalid) begin
            chk1("bus_req", bus_req, e_req);
            chk1("m0_addr_ok", m0_addr_ok, e_aok0);
            chk1("m1_addr_ok", m1_addr_ok, e_aok1);
            chk1("m0_data_ok", m0_data_ok, e_dok0);
            chk1("m1_data_ok", m1_data_ok, e_dok1);
            chk1("busy", busy, q_ids.size() != 0);
            chk1("err_spurious", err_spurious, err_m);
            chk32("rdata", rdata, bus_rdata);
            chk32("bus_addr", bus_addr, (e_gnt == 1) ? m1_addr : m0_addr);
            chk32("bus_wdata", bus_wdata, (e_gnt == 1) ? m1_wdata : m0_wdata);
            chk1("bus_wr", bus_wr, (e_gnt == 1) ? m1_wr : m0_wr);
            chk32("bus_size", 32'(bus_size), 32'((e_gnt == 1) ? m1_size : m0_size));
            chk32("bus_wstrb", 32'(bus_wstrb), 32'((e_gnt == 1) ? m1_wstrb : m0_wstrb));
        end
    endtask

    task automatic advance();
        bit pop, spur, push, waited1, rst_n;
        pop     = bus_data_ok && (q_ids.size() != 0);
        spur    = bus_data_ok && (q_ids.size() == 0);
        push    = e_req && bus_addr_ok;
        waited1 = m1_req && !e_aok1;
        rst_n   = reset;
        @(posedge clk);
        if (!rst_n) begin
            q_ids.delete();
            lk = 0; lk_m = 0; starve = 0; err_m = 0; mvalid = 1;
        end else begin
            if (pop)  void'(q_ids.pop_front());
            if (push) q_ids.push_back(e_gnt);
            if (spur) err_m = 1;
            lk   = e_req && !bus_addr_ok;
            lk_m = e_gnt;
            starve = waited1 ? ((starve < STARVE_LIMIT) ? starve + 1 : starve) : 0;
        end
        #1;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic idle();
        m0_req = 0; m0_wr = 0; m0_addr = 0; m0_size = 0; m0_wstrb = 0; m0_wdata = 0;
        m1_req = 0; m1_wr = 0; m1_addr = 0; m1_size = 0; m1_wstrb = 0; m1_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        step();
        step();
        reset = 1;
    endtask

    initial begin
        int m1_at, m1_cnt;
        logic [2:0] seq;
        reset = 0;
        idle();
        @(posedge clk);
        #1;

        // reset state
        do_reset();
        settle();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_bus_req", bus_req, 1'b0);
        chk1("rst_err", err_spurious, 1'b0);
        advance();

        // single M0 read, response three cycles later
        m0_req = 1; m0_addr = 32'h0000_1000; m0_size = 2; bus_addr_ok = 1;
        settle();
        chk1("t1_aok_c0", m0_addr_ok, 1'b1);
        chk1("t1_busy_c0", busy, 1'b0);
        advance();
        m0_req = 0; bus_addr_ok = 0;
        settle(); chk1("t1_busy_c1", busy, 1'b1); advance();
        settle(); chk1("t1_busy_c2", busy, 1'b1); advance();
        bus_data_ok = 1; bus_rdata = 32'hDEAD_BEEF;
        settle();
        chk1("t1_dok_c3", m0_data_ok, 1'b1);
        chk32("t1_rdata", rdata, 32'hDEAD_BEEF);
        advance();
        bus_data_ok = 0;
        settle(); chk1("t1_busy_c4", busy, 1'b0); advance();

        // starvation: M1 gets exactly one grant after 8 waiting cycles
        do_reset();
        m0_req = 1; m0_addr = 32'hA000_0000; m1_req = 1; m1_addr = 32'hB000_0000;
        bus_addr_ok = 1;
        m1_at = -1; m1_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            bus_data_ok = (c > 0);
            m0_addr = 32'hA000_0000 + 32'(c);
            settle();
            if (m1_addr_ok === 1'b1) begin
                m1_cnt++;
                if (m1_at < 0) m1_at = c;
            end
            advance();
            if (m1_at >= 0) m1_req = 0;
        end
        chk32("t2_m1_cycle", 32'(m1_at), 32'd8);
        chk32("t2_m1_grants", 32'(m1_cnt), 32'd1);
        m0_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        step();
        bus_data_ok = 0;

        // lock keeps M1 payload until accepted
        do_reset();
        m1_req = 1; m1_addr = 32'h0000_2000; m1_wr = 1; m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF;
        step();
        m0_req = 1; m0_addr = 32'h0000_3000;
        settle(); chk32("t3_locked_addr", bus_addr, 32'h0000_2000); advance();
        bus_addr_ok = 1;
        settle();
        chk32("t3_accept_addr", bus_addr, 32'h0000_2000);
        chk1("t3_m1_aok", m1_addr_ok, 1'b1);
        advance();
        m1_req = 0;
        settle();
        chk32("t3_next_addr", bus_addr, 32'h0000_3000);
        chk1("t3_m0_aok", m0_addr_ok, 1'b1);
        advance();
        m0_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        step(); step();
        bus_data_ok = 0;

        // full queue blocks requests
        do_reset();
        m0_req = 1; bus_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            m0_addr = 32'h100 * 32'(i);
            step();
        end
        settle();
        chk1("t4_full_req", bus_req, 1'b0);
        chk1("t4_full_aok", m0_addr_ok, 1'b0);
        advance();
        bus_data_ok = 1;
        settle(); chk1("t4_full_pop_req", bus_req, 1'b0); advance();
        settle(); chk1("t4_pushpop_req", bus_req, 1'b1); advance();
        bus_data_ok = 0;
        settle(); chk1("t4_refill_aok", m0_addr_ok, 1'b1); advance();
        settle(); chk1("t4_full_again", bus_req, 1'b0); advance();
        m0_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        for (int i = 0; i < 4; i++) step();
        bus_data_ok = 0;

        // response routing follows issue order
        do_reset();
        bus_addr_ok = 1;
        m0_req = 1; step();
        m0_req = 0; m1_req = 1; step();
        m1_req = 0; m0_req = 1; step();
        m0_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            seq[i] = m1_data_ok;
            advance();
        end
        bus_data_ok = 0;
        chk32("t5_order", 32'(seq), 32'h2);

        // spurious response and reset with outstanding requests
        do_reset();
        bus_data_ok = 1;
        settle();
        chk1("t6_no_dok0", m0_data_ok, 1'b0);
        chk1("t6_no_dok1", m1_data_ok, 1'b0);
        advance();
        bus_data_ok = 0;
        settle(); chk1("t6_err_set", err_spurious, 1'b1); advance();
        step(); step();
        m0_req = 1; bus_addr_ok = 1;
        step(); step();
        m0_req = 0; bus_addr_ok = 0;
        reset = 0;
        step();
        reset = 1;
        settle();
        chk1("t6_busy_after_rst", busy, 1'b0);
        chk1("t6_err_after_rst", err_spurious, 1'b0);
        advance();
        bus_data_ok = 1;
        step();
        bus_data_ok = 0;
        settle(); chk1("t6_late_resp_err", err_spurious, 1'b1); advance();

        // randomized traffic against the model
        do_reset();
        e_aok0 = 0; e_aok1 = 0;
        for (int c = 0; c < 600; c++) begin
            if (!m0_req || e_aok0) begin
                m0_req   = ($urandom_range(0, 99) < 50);
                m0_wr    = 1'($urandom_range(0, 1));
                m0_addr  = $urandom;
                m0_size  = 2'($urandom_range(0, 2));
                m0_wstrb = 4'($urandom);
                m0_wdata = $urandom;
            end
            if (!m1_req || e_aok1) begin
                m1_req   = ($urandom_range(0, 99) < 40);
                m1_wr    = 1'($urandom_range(0, 1));
                m1_addr  = $urandom;
                m1_size  = 2'($urandom_range(0, 2));
                m1_wstrb = 4'($urandom);
                m1_wdata = $urandom;
            end
            bus_addr_ok = ($urandom_range(0, 99) < 60);
            bus_data_ok = (q_ids.size() != 0) ? ($urandom_range(0, 99) < 45)
                                              : ($urandom_range(0, 99) < 2);
            bus_rdata   = $urandom;
            reset       = (c != 300);
            step();
        end
        reset = 1;
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
